// File: rtl/core_ctrl_pkg.sv
// Purpose: shared front-end control types (sequencer state, stall-cause codes) for sequencer, trace and debug logic.
// Latency: none; types, constants and a pure function only.
// Backpressure: not applicable.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        TRAP_FLUSH = 2'd1,
        HALT       = 2'd2,
        STEP       = 2'd3
    } pipe_state_t;

    // Stall-cause codes, highest-priority cause wins when several are active.
    localparam logic [2:0] STALL_NONE = 3'd0;
    localparam logic [2:0] STALL_MEM  = 3'd1;
    localparam logic [2:0] STALL_HZ   = 3'd2;
    localparam logic [2:0] STALL_RAS  = 3'd3;
    localparam logic [2:0] STALL_HALT = 3'd4;
    localparam logic [2:0] STALL_TRAP = 3'd5;

    // Classify the decode-side stall sources into one cause code.
    function automatic logic [2:0] stall_cause(input logic mem_hold, input logic hz, input logic ras_rdy);
        if (mem_hold)      return STALL_MEM;
        else if (hz)       return STALL_HZ;
        else if (!ras_rdy) return STALL_RAS;
        else               return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Purpose: bundles the sequencer's stall/redirect/debug inputs and per-stage strobes.
// Latency: wires only.
// Backpressure: none; the sequencer itself is the stall authority for IF/ID.
interface pipe_seq_ctrl_if #(
    parameter int WDOG_W = 8
);
    logic              hz;
    logic              ras_rdy;
    logic              mem_hold;
    logic              branch_taken;
    logic              trigger_trap;
    logic              trap_ret;
    logic              dbg_halt_req;
    logic              dbg_step;
    logic              dbg_resume;
    logic              if_en;
    logic              id_en;
    logic              id_bubble;
    logic              if_flush;
    logic              id_flush;
    logic              dbg_halted;
    logic [WDOG_W-1:0] stall_cnt;
    logic              wdog_err;

    // Pipeline/debug side: raises stall and redirect requests, consumes strobes.
    modport master (
        output hz, ras_rdy, mem_hold, branch_taken, trigger_trap, trap_ret,
               dbg_halt_req, dbg_step, dbg_resume,
        input  if_en, id_en, id_bubble, if_flush, id_flush, dbg_halted, stall_cnt, wdog_err
    );

    // Sequencer side.
    modport slave (
        input  hz, ras_rdy, mem_hold, branch_taken, trigger_trap, trap_ret,
               dbg_halt_req, dbg_step, dbg_resume,
        output if_en, id_en, id_bubble, if_flush, id_flush, dbg_halted, stall_cnt, wdog_err
    );
endinterface

// File: rtl/stall_wdog.sv
// Purpose: saturating consecutive-stall counter with sticky limit error.
// Latency: count and error update one clock after the qualifying cycle.
// Backpressure: none; stall_i takes precedence over clear_i if both are asserted.
module stall_wdog #(
    parameter int WDOG_W     = 8,
    parameter int WDOG_LIMIT = 200
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              stall_i,
    input  logic              clear_i,
    output logic [WDOG_W-1:0] cnt_o,
    output logic              err_o
);

    localparam logic [WDOG_W-1:0] CNT_MAX = '1;
    localparam logic [WDOG_W-1:0] LIM_M1  = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    // Next count: saturating increment on stall, clear on a real instruction advance.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (stall_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (cnt_q == LIM_M1)  err_d = 1'b1;
        end else if (clear_i) begin
            cnt_d = '0;
        end
    end

    // Counter and sticky error registers; only reset clears the error.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Purpose: merges IF/ID stall and redirect sources into stage strobes; owns debug halt/step and stall watchdog.
// Latency: strobes are combinational (same cycle); dbg_halted, stall_cnt, wdog_err are registered (+1 cycle).
// Backpressure: mem_hold freezes all strobes and sequencer state; hz/!ras_rdy hold IF and bubble ID/EX.
module pipe_seq_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int TRAP_DRAIN = 2,
    parameter int WDOG_W     = 8,
    parameter int WDOG_LIMIT = 200
) (
    input  logic             clk,
    input  logic             Rst,
    pipe_seq_ctrl_if.slave   bus
);

    localparam int            DW       = $clog2(TRAP_DRAIN) + 1;
    localparam logic [DW-1:0] DRAIN_M1 = DW'(TRAP_DRAIN - 1);

    pipe_state_t   state_q, state_d;
    logic          trap_pend_q, trap_pend_d;
    logic [DW-1:0] drain_q, drain_d;
    // Set when the current trap flush was started from a debug step, so it can land back in HALT.
    logic          step_trap_q, step_trap_d;
    logic          halted_q, halted_d;

    logic if_en, id_en, id_bubble, if_flush, id_flush;
    logic trap_any, wd_stall, wd_clear;
    logic [WDOG_W-1:0] stall_cnt;
    logic              wdog_err;

    assign trap_any = bus.trigger_trap | bus.trap_ret | trap_pend_q;

    // Next-state and strobe decode; RUN and STEP share the execute rules.
    always_comb begin
        state_d     = state_q;
        trap_pend_d = trap_pend_q;
        drain_d     = drain_q;
        step_trap_d = step_trap_q;
        if_en       = 1'b0;
        id_en       = 1'b0;
        id_bubble   = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        wd_stall    = 1'b0;
        case (state_q)
            RUN, STEP: begin
                wd_stall = (stall_cause(bus.mem_hold, bus.hz, bus.ras_rdy) != STALL_NONE);
                if (!bus.mem_hold) begin
                    if (trap_any) begin
                        if_en       = 1'b1;
                        id_en       = 1'b1;
                        id_bubble   = 1'b1;
                        if_flush    = 1'b1;
                        id_flush    = 1'b1;
                        trap_pend_d = 1'b0;
                        drain_d     = DRAIN_M1;
                        if (TRAP_DRAIN > 1) begin
                            state_d     = TRAP_FLUSH;
                            step_trap_d = (state_q == STEP);
                        end else begin
                            state_d = (state_q == STEP) ? HALT : RUN;
                        end
                    end else begin
                        if (bus.hz || !bus.ras_rdy) begin
                            id_en     = 1'b1;
                            id_bubble = 1'b1;
                        end else if (bus.branch_taken) begin
                            if_en    = 1'b1;
                            id_en    = 1'b1;
                            if_flush = 1'b1;
                        end else begin
                            if_en = 1'b1;
                            id_en = 1'b1;
                        end
                        // A step always ends in HALT; RUN halts on request after executing this cycle.
                        if (state_q == STEP || bus.dbg_halt_req) state_d = HALT;
                    end
                end
            end
            TRAP_FLUSH: begin
                // A memory freeze also freezes the flush, so no strobe leaks into a held pipeline.
                if (!bus.mem_hold) begin
                    if_en     = 1'b1;
                    id_en     = 1'b1;
                    id_bubble = 1'b1;
                    if_flush  = 1'b1;
                    id_flush  = 1'b1;
                    if (drain_q <= DW'(1)) begin
                        drain_d     = '0;
                        step_trap_d = 1'b0;
                        state_d     = (step_trap_q && bus.dbg_halt_req) ? HALT : RUN;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            HALT: begin
                if (bus.trigger_trap || bus.trap_ret) trap_pend_d = 1'b1;
                if (bus.dbg_resume)      state_d = RUN;
                else if (bus.dbg_step)   state_d = STEP;
            end
            default: state_d = RUN;
        endcase
    end

    // Debugger view: halted while parked, stepping, or draining a trap taken during a step.
    always_comb begin
        halted_d = (state_d == HALT) || (state_d == STEP) || ((state_d == TRAP_FLUSH) && step_trap_d);
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= RUN;
            trap_pend_q <= 1'b0;
            drain_q     <= '0;
            step_trap_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            trap_pend_q <= trap_pend_d;
            drain_q     <= drain_d;
            step_trap_q <= step_trap_d;
            halted_q    <= halted_d;
        end
    end

    // Clear only on a real instruction advancing into EX.
    assign wd_clear = id_en & ~id_bubble;

    stall_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .Rst     (Rst),
        .stall_i (wd_stall),
        .clear_i (wd_clear),
        .cnt_o   (stall_cnt),
        .err_o   (wdog_err)
    );

    // Strobes are forced low for the whole time reset is asserted.
    assign bus.if_en      = Rst & if_en;
    assign bus.id_en      = Rst & id_en;
    assign bus.id_bubble  = Rst & id_bubble;
    assign bus.if_flush   = Rst & if_flush;
    assign bus.id_flush   = Rst & id_flush;
    assign bus.dbg_halted = halted_q;
    assign bus.stall_cnt  = stall_cnt;
    assign bus.wdog_err   = wdog_err;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Purpose: self-checking bench for pipe_seq_ctrl with a per-cycle expected-output scoreboard.
// Latency: drives at posedge+1, compares at the following negedge.
// Backpressure: not applicable.
module tb_pipe_seq_ctrl;

    logic clk = 1'b0;
    logic Rst = 1'b0;

    always #5 clk = ~clk;

    pipe_seq_ctrl_if #(.WDOG_W(8)) bus_if ();

    pipe_seq_ctrl #(
        .TRAP_DRAIN (2),
        .WDOG_W     (8),
        .WDOG_LIMIT (200)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus_if)
    );

    // Input bits
    localparam logic [8:0] IDLE   = 9'h000;
    localparam logic [8:0] I_HZ   = 9'h001;
    localparam logic [8:0] I_RASN = 9'h002;
    localparam logic [8:0] I_MH   = 9'h004;
    localparam logic [8:0] I_BR   = 9'h008;
    localparam logic [8:0] I_TRAP = 9'h010;
    localparam logic [8:0] I_TRET = 9'h020;
    localparam logic [8:0] I_HALT = 9'h040;
    localparam logic [8:0] I_STEP = 9'h080;
    localparam logic [8:0] I_RES  = 9'h100;

    // Output pattern {if_en, id_en, id_bubble, if_flush, id_flush, dbg_halted, wdog_err}
    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_RUN  = 7'b1100000;
    localparam logic [6:0] O_BUB  = 7'b0110000;
    localparam logic [6:0] O_BR   = 7'b1101000;
    localparam logic [6:0] O_TRAP = 7'b1111100;
    localparam logic [6:0] H      = 7'b0000010;
    localparam logic [6:0] E      = 7'b0000001;

    typedef struct packed {
        logic [6:0] o;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, push expectation, pop and compare at negedge.
    task automatic cyc(input string tag, input logic [8:0] in, input logic [6:0] eo, input logic [7:0] ecnt);
        exp_t e;
        logic [6:0] obs;
        bus_if.hz           = in[0];
        bus_if.ras_rdy      = ~in[1];
        bus_if.mem_hold     = in[2];
        bus_if.branch_taken = in[3];
        bus_if.trigger_trap = in[4];
        bus_if.trap_ret     = in[5];
        bus_if.dbg_halt_req = in[6];
        bus_if.dbg_step     = in[7];
        bus_if.dbg_resume   = in[8];
        sb.push_back('{o: eo, cnt: ecnt});
        @(negedge clk);
        e   = sb.pop_front();
        obs = {bus_if.if_en, bus_if.id_en, bus_if.id_bubble, bus_if.if_flush,
               bus_if.id_flush, bus_if.dbg_halted, bus_if.wdog_err};
        chk($sformatf("%s#%0d.strobes", tag, n_cyc), {25'd0, obs}, {25'd0, e.o});
        chk($sformatf("%s#%0d.stall_cnt", tag, n_cyc), {24'd0, bus_if.stall_cnt}, {24'd0, e.cnt});
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset: strobes forced low even with redirect inputs active
        cyc("rst", IDLE, O_ZERO, 8'd0);
        cyc("rst_gate", I_TRAP | I_BR, O_ZERO, 8'd0);
        Rst = 1'b1;

        cyc("idle", IDLE, O_RUN, 8'd0);
        cyc("idle", IDLE, O_RUN, 8'd0);

        // Load-use hazard for three cycles
        cyc("hz", I_HZ, O_BUB, 8'd0);
        cyc("hz", I_HZ, O_BUB, 8'd1);
        cyc("hz", I_HZ, O_BUB, 8'd2);
        cyc("hz_done", IDLE, O_RUN, 8'd3);
        cyc("hz_clr", IDLE, O_RUN, 8'd0);

        // RAS not ready
        cyc("ras", I_RASN, O_BUB, 8'd0);
        cyc("ras_done", IDLE, O_RUN, 8'd1);
        cyc("ras_clr", IDLE, O_RUN, 8'd0);

        // Branch, and branch losing to a hazard
        cyc("br", I_BR, O_BR, 8'd0);
        cyc("br_hz", I_BR | I_HZ, O_BUB, 8'd0);
        cyc("br_hz_done", IDLE, O_RUN, 8'd1);
        cyc("br_hz_clr", IDLE, O_RUN, 8'd0);

        // Trap entry, trap+branch, trap return, trap with hazard
        cyc("trap", I_TRAP, O_TRAP, 8'd0);
        cyc("trap_drain", IDLE, O_TRAP, 8'd0);
        cyc("trap_done", IDLE, O_RUN, 8'd0);
        cyc("trapbr", I_TRAP | I_BR, O_TRAP, 8'd0);
        cyc("trapbr_drain", I_BR, O_TRAP, 8'd0);
        cyc("trapbr_done", IDLE, O_RUN, 8'd0);
        cyc("tret", I_TRET, O_TRAP, 8'd0);
        cyc("tret_drain", IDLE, O_TRAP, 8'd0);
        cyc("tret_done", IDLE, O_RUN, 8'd0);
        cyc("traphz", I_TRAP | I_HZ, O_TRAP, 8'd0);
        cyc("traphz_drain", IDLE, O_TRAP, 8'd1);
        cyc("traphz_done", IDLE, O_RUN, 8'd1);
        cyc("traphz_clr", IDLE, O_RUN, 8'd0);

        // Debug halt, a clean step, trap_ret while halted, a trap-servicing step, resume
        cyc("halt_req", I_HALT, O_RUN, 8'd0);
        cyc("halt_hz", I_HALT | I_HZ, O_ZERO | H, 8'd0);
        cyc("halt", I_HALT, O_ZERO | H, 8'd0);
        cyc("step1_req", I_HALT | I_STEP, O_ZERO | H, 8'd0);
        cyc("step1_exec", I_HALT, O_RUN | H, 8'd0);
        cyc("step1_back", I_HALT, O_ZERO | H, 8'd0);
        cyc("halt_tret", I_HALT | I_TRET, O_ZERO | H, 8'd0);
        cyc("halt_wait", I_HALT, O_ZERO | H, 8'd0);
        cyc("step2_req", I_HALT | I_STEP, O_ZERO | H, 8'd0);
        cyc("step2_exec", I_HALT, O_TRAP | H, 8'd0);
        cyc("step2_drain", I_HALT, O_TRAP | H, 8'd0);
        cyc("step2_back", I_HALT, O_ZERO | H, 8'd0);
        cyc("resume", I_RES | I_STEP, O_ZERO | H, 8'd0);
        cyc("resumed", IDLE, O_RUN, 8'd0);
        cyc("resumed", IDLE, O_RUN, 8'd0);

        // Memory hold for WDOG_LIMIT cycles
        for (int i = 0; i < 200; i++) begin
            cyc("mhold", I_MH, O_ZERO, 8'(i));
        end
        cyc("wdog_rise", IDLE, O_RUN | E, 8'd200);
        cyc("wdog_sticky", IDLE, O_RUN | E, 8'd0);

        // Reset mid trap flush
        cyc("rtrap", I_TRAP, O_TRAP | E, 8'd0);
        Rst = 1'b0;
        cyc("rtrap_rst", IDLE, O_ZERO, 8'd0);
        Rst = 1'b1;
        cyc("rtrap_rel", IDLE, O_RUN, 8'd0);
        cyc("rtrap_rel", IDLE, O_RUN, 8'd0);

        // Reset mid halt with a pending trap
        cyc("rhalt_req", I_HALT, O_RUN, 8'd0);
        cyc("rhalt_trap", I_HALT | I_TRAP, O_ZERO | H, 8'd0);
        Rst = 1'b0;
        cyc("rhalt_rst", I_HALT, O_ZERO, 8'd0);
        Rst = 1'b1;
        cyc("rhalt_rel", IDLE, O_RUN, 8'd0);
        cyc("rhalt_rel", IDLE, O_RUN, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
